aes_key_expand: RTL and testbench

Sequential AES-128 key-schedule generator that produces the 11 round keys (rounds 0..10) from a 128-bit cipher key, one key per accepted handshake. It sits upstream of the encryption round datapath. It drives the RotWord output of the last key word into four byte S-box lookups (SubWord) and consumes their substituted bytes to form the next round key. The round datapath pulls keys with a valid/ready handshake, so the block can run at full rate or be throttled.

---
 rtl/aes_pkg.sv | 45 ++++
 rtl/aes_sbox.sv | 39 +++
 rtl/aes_sub_word.sv | 16 +
 rtl/aes_key_expand.sv | 93 +++++++++
 tb/tb_aes_key_expand.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and helpers.
//   AES_NR / AES_KEY_W / AES_WORD_W : AES-128 geometry (Nk=4, Nr=10)
//   RCON                            : round constants for rounds 1..10
//   state_t                         : key-schedule FSM states
//   gf_mul / rcon_of                : GF(2^8) multiply, guarded RCON lookup
package aes_pkg;

  localparam int AES_NR     = 10;
  localparam int AES_KEY_W  = 128;
  localparam int AES_WORD_W = 32;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic {
    IDLE = 1'b0,
    OUT  = 1'b1
  } state_t;

  // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // RCON for a round index; indices outside 1..10 yield 0 so the lookup
  // stays in range when the schedule is already on its last key.
  function automatic logic [7:0] rcon_of(input logic [3:0] round);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      if (round == 4'(i)) r = RCON[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward byte S-box, computed rather than tabulated.
//   a : input byte
//   s : substituted byte
// The multiplicative inverse is a^254 (0 maps to 0), followed by the
// standard affine transform with constant 8'h63.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  logic [7:0] x2, x3, x6, x12, x14, x15, x30, x60, x120, x240, inv;

  always_comb begin
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x14  = gf_mul(x12, x2);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(x240, x14);
  end

  localparam logic [7:0] AFFINE_C = 8'h63;

  always_comb begin
    s = 8'h00;
    for (int i = 0; i < 8; i++) begin
      s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^
             inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ AFFINE_C[i];
    end
  end

endmodule

// File: rtl/aes_sub_word.sv
// 32-bit SubWord: byte S-box applied independently to each byte.
//   w_in  : input word
//   w_out : substituted word, same byte order
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [AES_WORD_W-1:0] w_in,
  output logic [AES_WORD_W-1:0] w_out
);

  aes_sbox u_sbox3 (.a(w_in[31:24]), .s(w_out[31:24]));
  aes_sbox u_sbox2 (.a(w_in[23:16]), .s(w_out[23:16]));
  aes_sbox u_sbox1 (.a(w_in[15:8]),  .s(w_out[15:8]));
  aes_sbox u_sbox0 (.a(w_in[7:0]),   .s(w_out[7:0]));

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: emits round keys 0..10, one per handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   start, key : begin expansion of key (accepted only in IDLE)
//   rk_ready   : consumer takes rk this cycle
//   busy       : expansion in progress
//   rk_valid   : rk / rk_round hold a round key
//   rk_round   : round index of rk (0..10)
//   rk         : round key, w0 in [127:96]
//   done       : one-cycle pulse after the round-10 handshake
//   state_dbg  : current FSM state (IDLE=0, OUT=1)
// Handshake: a key transfers on a rising edge where rk_valid && rk_ready;
// while rk_valid is high and rk_ready is low, rk and rk_round hold steady.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AES_KEY_W-1:0] key,
  input  logic                 rk_ready,
  output logic                 busy,
  output logic                 rk_valid,
  output logic [3:0]           rk_round,
  output logic [AES_KEY_W-1:0] rk,
  output logic                 done,
  output logic                 state_dbg
);

  localparam logic [3:0] LAST_ROUND = 4'(AES_NR);

  state_t state;

  logic [AES_WORD_W-1:0] w0, w1, w2, w3;
  logic [AES_WORD_W-1:0] rot_w, sub_w, t;
  logic [AES_WORD_W-1:0] n0, n1, n2, n3;

  assign w0 = rk[127:96];
  assign w1 = rk[95:64];
  assign w2 = rk[63:32];
  assign w3 = rk[31:0];

  assign rot_w = {w3[23:0], w3[31:24]};

  aes_sub_word u_sub_word (.w_in(rot_w), .w_out(sub_w));

  // Single-cycle next-key path: rk register -> SubWord -> XOR chain -> rk D.
  assign t  = sub_w ^ {rcon_of(rk_round + 4'd1), 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rk       <= '0;
      rk_round <= '0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rk       <= key;
            rk_round <= '0;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= OUT;
          end
        end
        OUT: begin
          if (rk_ready) begin
            if (rk_round == LAST_ROUND) begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              rk       <= {n0, n1, n2, n3};
              rk_round <= rk_round + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: directed sequence with random keys and random
// backpressure, checked against a word-level key-schedule model.
module tb_aes_key_expand;

  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_A1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KEY_A10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_Z1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] KEY_Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic         rk_ready;
  logic         busy;
  logic         rk_valid;
  logic [3:0]   rk_round;
  logic [127:0] rk;
  logic         done;
  logic         state_dbg;

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key       (key),
    .rk_ready  (rk_ready),
    .busy      (busy),
    .rk_valid  (rk_valid),
    .rk_round  (rk_round),
    .rk        (rk),
    .done      (done),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] exp_q[$];
  logic [127:0] got_rk [0:10];
  logic [7:0]   sbox_t [0:255];

  // ---------------- reference model ----------------
  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = (v << n) | (v >> (8 - n));
    return r;
  endfunction

  // S-box table from the generator walk over GF(2^8)* (p steps by 3,
  // q by 1/3), independent of any inversion circuit.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_word_m(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // FIPS-197 word recurrence over w[0..43]; pushes the 11 round keys.
  task automatic load_model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    exp_q.delete();
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = sub_word_m({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) exp_q.push_back({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_key(input logic [127:0] k);
    start = 1'b1;
    key   = k;
  endtask

  // Runs one expansion from the negedge after start_key until done is seen.
  // pct: chance (percent) of rk_ready per cycle. inject: pulse start with
  // alt_key while busy. Returns the number of edges from start to done.
  task automatic collect(input int pct, input bit inject, input logic [127:0] alt_key,
                         output int cycles);
    int           cnt;
    int           hs;
    int           exp_round;
    bit           stalled;
    bit           fin;
    logic [127:0] prev_rk;
    logic [3:0]   prev_round;
    logic [127:0] e;
    cnt = 0; hs = 0; exp_round = 0; stalled = 0; fin = 0;
    prev_rk = '0; prev_round = '0;
    while (!fin) begin
      @(negedge clk);
      cnt++;
      start = inject && (cnt == 3);
      if (inject && cnt == 3) key = alt_key;
      if (cnt == 1) begin
        check("first_valid", 128'(rk_valid), 128'd1);
        check("first_round", 128'(rk_round), 128'd0);
      end
      if (stalled) begin
        check("stall_rk", rk, prev_rk);
        check("stall_round", 128'(rk_round), 128'(prev_round));
      end
      if (done) begin
        check("done_busy", 128'(busy), 128'd0);
        check("done_valid", 128'(rk_valid), 128'd0);
        fin = 1;
      end else if (cnt > 600) begin
        n_checks++;
        n_fail++;
        $error("FAIL timeout: observed no done after %0d cycles, expected done", cnt);
        fin = 1;
      end else begin
        rk_ready = ($urandom_range(0, 99) < pct);
        if (rk_valid && rk_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL extra_key: observed round %0d, expected no more keys", rk_round);
          end else begin
            e = exp_q.pop_front();
            check("rk", rk, e);
            check("rk_round", 128'(rk_round), 128'(exp_round));
            if (exp_round <= 10) got_rk[exp_round] = rk;
          end
          exp_round++;
          hs++;
        end
        stalled    = rk_valid && !rk_ready;
        prev_rk    = rk;
        prev_round = rk_round;
      end
    end
    check("handshakes", 128'(hs), 128'd11);
    check("queue_empty", 128'(exp_q.size()), 128'd0);
    cycles = cnt;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_rk"}, rk, 128'd0);
    check({tag, "_round"}, 128'(rk_round), 128'd0);
    check({tag, "_valid"}, 128'(rk_valid), 128'd0);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_done"}, 128'(done), 128'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int           cyc;
    int           guard;
    logic [127:0] rkey;
    rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; key = '0;
    build_sbox();
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    check("reset_state", 128'(state_dbg), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 App. A key at full rate
    load_model(KEY_A);
    start_key(KEY_A);
    collect(100, 1'b0, '0, cyc);
    check("a_done_latency", 128'(cyc), 128'd12);
    check("a_round0", got_rk[0], KEY_A);
    check("a_round1", got_rk[1], KEY_A1);
    check("a_round10", got_rk[10], KEY_A10);
    @(negedge clk);
    check("a_done_width", 128'(done), 128'd0);

    // all-zero key
    load_model('0);
    start_key('0);
    collect(100, 1'b0, '0, cyc);
    check("z_round0", got_rk[0], 128'd0);
    check("z_round1", got_rk[1], KEY_Z1);
    check("z_round10", got_rk[10], KEY_Z10);
    @(negedge clk);

    // backpressure, about 30% ready
    load_model(KEY_A);
    start_key(KEY_A);
    collect(30, 1'b0, '0, cyc);
    check("bp_round1", got_rk[1], KEY_A1);
    check("bp_round10", got_rk[10], KEY_A10);
    @(negedge clk);

    // start with another key while busy must be ignored
    load_model(KEY_A);
    start_key(KEY_A);
    collect(50, 1'b1, {$urandom, $urandom, $urandom, $urandom}, cyc);
    check("ign_round10", got_rk[10], KEY_A10);
    @(negedge clk);

    // asynchronous reset while stalled on round 5
    start_key(KEY_A);
    guard = 0;
    while (guard < 50) begin
      @(negedge clk);
      start = 1'b0;
      guard++;
      if (rk_valid && rk_round == 4'd5) begin
        rk_ready = 1'b0;
        break;
      end
      rk_ready = 1'b1;
    end
    check("rst_reached_r5", 128'(rk_round), 128'd5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_zero("post_rst");
    load_model(KEY_A);
    start_key(KEY_A);
    collect(40, 1'b0, '0, cyc);
    check("rst_round10", got_rk[10], KEY_A10);

    // back-to-back: new start in the done cycle
    @(negedge clk);
    load_model(KEY_A);
    start_key(KEY_A);
    collect(100, 1'b0, '0, cyc);
    load_model('0);
    start_key('0);
    collect(100, 1'b0, '0, cyc);
    check("b2b_round0", got_rk[0], 128'd0);
    check("b2b_round10", got_rk[10], KEY_Z10);
    @(negedge clk);

    // random keys, random throttle
    for (int n = 0; n < 4; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      load_model(rkey);
      start_key(rkey);
      collect($urandom_range(20, 100), 1'b0, '0, cyc);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
